// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa.sv
// 1-bit full adder, purely combinational.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first through one full adder: done pulses WIDTH+1 cycles after an accepted start;
// start is ignored while busy/done. Optional subtraction (a + ~b + 1) under SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    fa u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_in;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa    <= {1'b0, opa[WIDTH-1:1]};
                    opb    <= {1'b0, opb[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    // Visible result only moves on the edge that completes the last bit.
                    if (last_bit) begin
                        sum  <= {fa_s, res_sh[WIDTH-1:1]};
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic         c;
        logic [W-1:0] s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    exp_t         sb_q[$];
    logic [W-1:0] last_sum;
    logic         last_cout;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain; 1: scramble operands mid-run; 2: re-pulse start mid-run; 3: reset at 4th run cycle
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic cin_i,
                          input logic sub_i, input int mode);
        logic [W:0] full;
        exp_t       e;
        exp_t       got;
        int         busy_n;
        int         done_n;
        int         done_cyc;
        @(negedge clk);
        a     = a_i;
        b     = b_i;
        cin   = cin_i;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = sub_i;
        full  = sub_i ? ({1'b0, a_i} + {1'b0, ~b_i} + 9'd1) : ({1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i});
`else
        full  = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
        if (sub_i) full = full;
`endif
        e.c   = full[W];
        e.s   = full[W-1:0];
        start = 1'b1;
        if (mode != 3) sb_q.push_back(e);
        @(posedge clk);
        busy_n   = 0;
        done_n   = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (busy) begin
                busy_n++;
                chk("sum_held_in_run", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
            end
            if (mode == 1 && cyc == 3) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = ~cin;
            end
            if (mode == 2 && cyc == 2) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end
            if (mode == 2 && cyc == 3) start = 1'b0;
            if (mode == 3 && cyc == 4) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_sum", {24'd0, sum}, 32'd0);
                chk("rst_cout", {31'd0, cout}, 32'd0);
                last_sum  = '0;
                last_cout = 1'b0;
            end
            if (mode == 3 && cyc == 6) rst = 1'b0;
            if (done) begin
                done_n++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e   = sb_q.pop_front();
                        got = '{c: cout, s: sum};
                        chk("sum", {24'd0, got.s}, {24'd0, e.s});
                        chk("cout", {31'd0, got.c}, {31'd0, e.c});
                        last_sum  = e.s;
                        last_cout = e.c;
                    end
                end
            end
            if (done_cyc != 0 && cyc == done_cyc + 3) break;
        end
        if (mode == 3) begin
            chk("abort_no_done", done_n, 0);
        end else begin
            chk("done_cycle", done_cyc, W + 1);
            chk("busy_cycles", busy_n, W);
            chk("single_done", done_n, 1);
            chk("sum_held_idle", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        last_sum  = '0;
        last_cout = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum", {24'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1);
        run_op(8'h3C, 8'h42, 1'b0, 1'b0, 2);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 3);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0);
        end
`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on an accepted start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  WIDTH  result; held until the next accepted start.
REQ-011 SHALL have port cout  output  1  final carry-out; held with sum.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start only when in IDLE with start=1 at a rising edge: capture a, b and cin, clear the bit counter, enter RUN.
REQ-014 SHALL in RUN process one bit per cycle, LSB first, through a single 1-bit full-adder instance: sum bit i = a[i]^b[i]^c; carry register updated to the full-adder carry.
REQ-015 SHALL shift each sum bit into the result register MSB-side, so that sum[WIDTH-1:0] is correctly ordered after WIDTH bits.
REQ-016 SHALL leave RUN for DONE at the edge that processes bit WIDTH-1, giving exactly WIDTH RUN cycles.
REQ-017 SHALL hold DONE for exactly one cycle with done=1, then return unconditionally to IDLE.
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the accepting edge; sum and cout SHALL be valid while done=1.
REQ-019 SHALL ignore start while in RUN or DONE; captured operands SHALL NOT change.
REQ-020 SHALL ignore changes on a, b and cin after capture.
REQ-021 SHALL not update sum or cout during RUN; the visible sum and cout SHALL change only on the edge entering DONE.
REQ-022 SHALL drop carries beyond cout; the result is (a+b+cin) mod 2^(WIDTH+1).

Reset
REQ-023 SHALL on rst=1, immediately and regardless of clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, carry register=0 and bit counter=0.
REQ-024 SHALL abort any RUN in progress on reset, with no done pulse; the first accepted start after rst deasserts begins a fresh operation.

Configuration
REQ-025 SHALL gate subtraction with macro SERIAL_ADDER_SUB_EN.
REQ-026 SHALL with SERIAL_ADDER_SUB_EN defined add input port sub (1 bit, captured on start); when sub=1, compute a + ~b + 1 (cin ignored), with cout=1 meaning no borrow.
REQ-027 SHALL without SERIAL_ADDER_SUB_EN have no sub port and perform addition only.

Structure
REQ-028 SHALL place the FSM state enum, state width constant and default WIDTH in shared package serial_adder_pkg.
REQ-029 SHALL instantiate the existing 1-bit full-adder module fa as its sole sub-module; no other arithmetic.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0, done 9 cycles after the start edge.
REQ-031 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy high for exactly 8 cycles.
REQ-032 SHALL cover: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; operands changed mid-RUN do not affect the result.
REQ-033 SHALL cover: start pulsed again during RUN with new operands -> ignored; single done, result of first operands only.
REQ-034 SHALL cover: rst asserted at the 4th RUN cycle -> outputs zero immediately, no done; the next start with a=8'h03, b=8'h04 -> sum=8'h07.
REQ-035 SHALL cover, with SERIAL_ADDER_SUB_EN: a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, cout=1; a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, cout=0.
